// File: rtl/local_memory_wishbone_requester_if.sv
// Wishbone classic slave lines plus the enable/busy local-memory request port.
interface local_memory_wishbone_requester_if #(
  parameter int ADDRESS_SIZE = 24
);
  logic                    wb_cyc_i;
  logic                    wb_stb_i;
  logic                    wb_we_i;
  logic [3:0]              wb_sel_i;
  logic [31:0]             wb_adr_i;
  logic [31:0]             wb_data_i;
  logic                    wb_ack_o;
  logic                    wb_error_o;
  logic [31:0]             wb_data_o;
  logic [ADDRESS_SIZE-1:0] memAddress;
  logic [3:0]              memByteSelect;
  logic                    memEnable;
  logic                    memWriteEnable;
  logic [31:0]             memDataWrite;
  logic [31:0]             memDataRead;
  logic                    memBusy;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_data_i,
    output wb_ack_o, wb_error_o, wb_data_o,
    output memAddress, memByteSelect, memEnable, memWriteEnable, memDataWrite,
    input  memDataRead, memBusy
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_data_i,
    input  wb_ack_o, wb_error_o, wb_data_o,
    input  memAddress, memByteSelect, memEnable, memWriteEnable, memDataWrite,
    output memDataRead, memBusy
  );
endinterface

// File: rtl/local_memory_wishbone_requester.sv
// Wishbone classic slave -> local-memory requester; ack 2 cycles after strobe plus one per
// memBusy cycle; holds the request while memBusy is high, errors the bus after TIMEOUT_CYCLES.
module local_memory_wishbone_requester #(
  parameter int                       ADDRESS_SIZE   = 24,
  parameter logic [31-ADDRESS_SIZE:0] WINDOW_BASE    = '0,
  parameter int                       TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst,
  local_memory_wishbone_requester_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQUEST = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;
  localparam logic [1:0] ERROR   = 2'd3;

  localparam int            CW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]              state;
  logic [CW-1:0]           busyCount;
  logic [ADDRESS_SIZE-1:0] addrReg;
  logic [3:0]              selReg;
  logic                    weReg;
  logic [31:0]             wdataReg;
  logic [31:0]             rdataReg;
  logic                    inWindow;

  assign inWindow = (bus.wb_adr_i[31:ADDRESS_SIZE] == WINDOW_BASE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busyCount <= '0;
      addrReg   <= '0;
      selReg    <= '0;
      weReg     <= 1'b0;
      wdataReg  <= '0;
      rdataReg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Out-of-window strobes are left for the bus decoder to answer.
          if (bus.wb_cyc_i && bus.wb_stb_i && inWindow) begin
            addrReg   <= bus.wb_adr_i[ADDRESS_SIZE-1:0];
            selReg    <= bus.wb_sel_i;
            weReg     <= bus.wb_we_i;
            wdataReg  <= bus.wb_data_i;
            busyCount <= '0;
            state     <= REQUEST;
          end
        end
        REQUEST: begin
          // Abort beats completion: memEnable is already low when cyc drops.
          if (!bus.wb_cyc_i) begin
            state <= IDLE;
          end else if (!bus.memBusy) begin
            rdataReg <= weReg ? 32'h0 : bus.memDataRead;
            state    <= RESPOND;
          end else if ((TIMEOUT_CYCLES != 0) && (busyCount == LAST)) begin
            state <= ERROR;
          end else if (busyCount != {CW{1'b1}}) begin
            busyCount <= busyCount + CW'(1);
          end
        end
        RESPOND: state <= IDLE;
        ERROR:   state <= IDLE;
      endcase
    end
  end

  assign bus.memEnable      = (state == REQUEST) && bus.wb_cyc_i;
  assign bus.memWriteEnable = bus.memEnable && weReg;
  assign bus.memAddress     = addrReg;
  assign bus.memByteSelect  = selReg;
  assign bus.memDataWrite   = wdataReg;

  assign bus.wb_ack_o   = (state == RESPOND);
  assign bus.wb_error_o = (state == ERROR);
  assign bus.wb_data_o  = (state == RESPOND) ? rdataReg : 32'h0;
endmodule

// File: doc/local_memory_wishbone_requester.md
# local_memory_wishbone_requester

Wishbone classic slave that turns bus cycles into requests on a local-memory request port (enable/busy handshake on the address, byte-select, write-enable and data lines). It is the initiator end of that port and sits between the management Wishbone bus and the secondary port of the core's local memory interface. It latches one bus transaction, holds the memory request until the memory drops busy, then acknowledges the bus. A busy timeout ends the bus cycle with an error.

## Interface
- ADDRESS_SIZE, 24: width of the local memory byte address.
- WINDOW_BASE, 8'h00: value that wb_adr_i[31:ADDRESS_SIZE] must equal for the block to respond.
- TIMEOUT_CYCLES, 255: maximum number of busy cycles per request; 0 disables the timeout.

- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  reset, asynchronous and active-high.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1  Wishbone cycle, strobe, write.
- wb_sel_i  in  4  Wishbone byte select.
- wb_adr_i  in  32  Wishbone byte address.
- wb_data_i  in  32  Wishbone write data.
- wb_ack_o  out  1  one-cycle acknowledge.
- wb_error_o  out  1  one-cycle error, used on timeout.
- wb_data_o  out  32  read data; valid while wb_ack_o=1, otherwise 0.
- memAddress  out  ADDRESS_SIZE  request byte address.
- memByteSelect  out  4  request byte lanes.
- memEnable  out  1  request valid.
- memWriteEnable  out  1  1 = write, 0 = read.
- memDataWrite  out  32  write data.
- memDataRead  in  32  read data; valid in the completion cycle.
- memBusy  in  1  high while the request is not yet complete.

## Operation
- Memory port rules:
  - The request lines hold constant while memEnable=1.
  - A request completes at the rising edge where memEnable=1 and memBusy=0.
  - memEnable must be 0 in the cycle after completion.
- FSM states: IDLE, REQUEST, RESPOND, ERROR.
- IDLE:
  - If wb_cyc_i & wb_stb_i and the address is in the window: register wb_adr_i[ADDRESS_SIZE-1:0], wb_sel_i, wb_we_i and wb_data_i onto the mem* outputs; clear the timeout counter; go to REQUEST.
  - If the address is out of the window: stay in IDLE and never acknowledge; the bus decoder owns this case.
- REQUEST:
  - memEnable=1.
  - If memBusy=0: register memDataRead (reads only; writes store 0); go to RESPOND.
  - Else if TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES-1: go to ERROR.
  - Else: counter+1.
  - Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1; it saturates and never wraps.
- RESPOND: wb_ack_o=1 and wb_data_o=captured data for one cycle; next state IDLE.
- ERROR: wb_error_o=1 for one cycle; next state IDLE.
- memEnable is 0 in IDLE, RESPOND and ERROR.
- The mem* address, select and data outputs keep their last values outside REQUEST. memWriteEnable is also forced to 0 whenever memEnable=0.
- Abort rule:
  - If wb_cyc_i falls in REQUEST, go to IDLE next cycle with no ack or error.
  - memEnable drops at once (it is gated combinationally by wb_cyc_i).
  - Whether an aborted write reached memory is undefined.
- Completion and timeout in the same cycle: completion wins and goes to RESPOND.
- The cycle after ack or error is spent in IDLE. A strobe still high in that cycle starts a new transaction, per classic Wishbone.

## Timing
- Reset: state IDLE.
  - Zero: wb_ack_o, wb_error_o, wb_data_o, memEnable, memWriteEnable, memByteSelect, memAddress, memDataWrite, and the counter.
  - Asynchronous assertion takes effect immediately, including mid-request; memEnable drops without waiting for the clock.
- Strobe sampled at edge 0 gives memEnable=1 in cycle 1.
- Completion at edge k gives wb_ack_o in cycle k+1.
- Minimum latency is 2 cycles from strobe sample to ack (memBusy=0 in cycle 1). Each busy cycle adds 1.
- Timeout: with memBusy held high, wb_error_o asserts in cycle TIMEOUT_CYCLES+1.
- No combinational path from memBusy or memDataRead to any Wishbone output.

## Test plan
- Write:
  - Stimulus: adr=0x0000_0104, sel=4'b0011, data=0xDEADBEEF; memBusy high for 2 cycles.
  - Required: memAddress=0x000104, memByteSelect=4'b0011, memWriteEnable=1; memEnable high for 3 cycles; ack in cycle 4, one cycle wide.
- Read:
  - Stimulus: adr=0x0000_0200, sel=4'hF; memBusy=0 at once; memDataRead=0x12345678.
  - Required: ack in cycle 2 with wb_data_o=0x12345678; wb_data_o=0 in the following cycle.
- Out of window:
  - Stimulus: adr=0x0100_0000 with WINDOW_BASE=0.
  - Required: memEnable stays 0 and no ack for 20 cycles.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4, memBusy held at 1.
  - Required: wb_error_o pulses in cycle 5; memEnable=0 from cycle 5; no ack.
- Abort and reset:
  - Stimulus: drop wb_cyc_i in cycle 2 of a busy request.
  - Required: memEnable=0 in that cycle; IDLE; no ack.
  - Stimulus: assert rst mid-REQUEST.
  - Required: all outputs 0 before the next edge.
- Back-to-back: two reads with strobe re-asserted the cycle after ack; both acknowledged, each with its own data.
